// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// register-number width, Control_Unit signal bit positions and the
// load-use hazard detector.
package hazard_sequencer_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_IMM  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Architectural register number width
  localparam int REG_W = 3;

  // Resume target recorded while waiting on data memory
  localparam logic RET_RUN = 1'b0;
  localparam logic RET_IMM = 1'b1;

  // WB_signals bit positions as packed by Control_Unit
  localparam int WB_REG_WRITE_BIT  = 0;
  localparam int WB_MEM_TO_REG_BIT = 1;

  // MEM_signals bit positions as packed by Control_Unit
  localparam int MEM_READ_BIT  = 0;
  localparam int MEM_WRITE_BIT = 1;

  // A load in EX whose destination is read by the instruction in ID
  function automatic logic load_use_hazard(
    input logic             mem_read,
    input logic [REG_W-1:0] src1,
    input logic             use1,
    input logic [REG_W-1:0] src2,
    input logic             use2,
    input logic [REG_W-1:0] rdst
  );
    logic hit1;
    logic hit2;
    hit1 = use1 & (src1 == rdst);
    hit2 = use2 & (src2 == rdst);
    return mem_read & (hit1 | hit2);
  endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter used for the performance debug counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already pinned at all-ones
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_C)) begin
      count_d = count_q + ONE_C;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, LDM immediate capture
// and data-memory wait states with a timeout watchdog.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cu_flush,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_rdst,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             imm_capture,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  import hazard_sequencer_pkg::*;

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] ONE_C     = WCNT_W'(1);

  state_e            state_q, state_d;
  logic              ret_q, ret_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic   hazard_s;
  logic   busy_s;
  logic   resolve_s;   // RUN/IMM rules apply this cycle
  state_e eval_s;      // which of RUN/IMM supplies the rules
  logic   pc_write_s, if_id_write_s, bubble_s, imm_s, hold_s, stall_ev_s;

  assign hazard_s = load_use_hazard(ex_mem_read, id_src1, id_use1,
                                    id_src2, id_use2, ex_rdst);

  // Next state and combinational control outputs
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    bubble_s      = 1'b0;
    imm_s         = 1'b0;
    hold_s        = 1'b0;
    stall_ev_s    = 1'b0;
    busy_s        = mem_req & ~mem_ready;
    resolve_s     = 1'b1;
    eval_s        = state_q;

    // In WAIT either keep holding, or treat memory as ready and fall
    // through to the rules of the state we were waiting from.
    if (state_q == ST_WAIT) begin
      if (!mem_ready && (wait_cnt_q < TIMEOUT_C)) begin
        resolve_s     = 1'b0;
        hold_s        = 1'b1;
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        wait_cnt_d    = wait_cnt_q + ONE_C;
      end else begin
        if (!mem_ready) begin
          timeout_d = 1'b1;
        end else begin
          timeout_d = timeout_q;
        end
        wait_cnt_d = '0;
        busy_s     = 1'b0;
        eval_s     = (ret_q == RET_IMM) ? ST_IMM : ST_RUN;
      end
    end else begin
      eval_s = state_q;
    end

    if (resolve_s) begin
      case (eval_s)
        ST_IMM: begin
          // LDM in EX: capture its immediate and squash the IF/ID word
          if (busy_s) begin
            hold_s        = 1'b1;
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            state_d       = ST_WAIT;
            ret_d         = RET_IMM;
            wait_cnt_d    = ONE_C;
          end else begin
            imm_s    = 1'b1;
            bubble_s = 1'b1;
            state_d  = ST_RUN;
          end
        end
        default: begin
          // RUN (and recovery from the unused encoding)
          if (busy_s) begin
            hold_s        = 1'b1;
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            state_d       = ST_WAIT;
            ret_d         = RET_RUN;
            wait_cnt_d    = ONE_C;
          end else if (hazard_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            bubble_s      = 1'b1;
            stall_ev_s    = 1'b1;
            state_d       = ST_RUN;
          end else if (cu_flush) begin
            state_d = ST_IMM;
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Reset freezes the front end and injects bubbles
    if (rst) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      bubble_s      = 1'b1;
      imm_s         = 1'b0;
      hold_s        = 1'b0;
      stall_ev_s    = 1'b0;
    end else begin
      stall_ev_s = stall_ev_s;
    end
  end

  // State, resume target, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ret_q      <= RET_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_ev_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_s),
    .count (hold_cnt)
  );

  assign pc_write     = pc_write_s;
  assign if_id_write  = if_id_write_s;
  assign id_ex_bubble = bubble_s;
  assign imm_capture  = imm_s;
  assign pipe_hold    = hold_s;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_sequencer;

  localparam int TO   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, cu_flush, id_use1, id_use2, ex_mem_read, mem_req, mem_ready;
  logic [2:0] id_src1, id_src2, ex_rdst;
  logic pc_write, if_id_write, id_ex_bubble, imm_capture, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, hold_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cu_flush(cu_flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_mem_read(ex_mem_read), .ex_rdst(ex_rdst),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .imm_capture(imm_capture), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .hold_cnt(hold_cnt)
  );

  // ---------------- behavioural model ----------------
  bit m_imm_next  = 1'b0;  // the IF/ID word is an LDM immediate
  int m_waited    = 0;     // cycles already spent waiting (0 = not waiting)
  bit m_resume_imm = 1'b0;
  bit m_flag      = 1'b0;
  int m_stalls    = 0;
  int m_holds     = 0;

  typedef struct {
    bit pc, ifid, bub, cap, hold, stall_ev;
    bit n_imm, n_resume, n_flag;
    int n_waited;
  } mres_t;

  function automatic mres_t model_eval();
    mres_t r;
    bit haz, busy, imm;
    r.pc = 1; r.ifid = 1; r.bub = 0; r.cap = 0; r.hold = 0; r.stall_ev = 0;
    r.n_imm = m_imm_next; r.n_resume = m_resume_imm; r.n_flag = m_flag; r.n_waited = 0;
    if (rst) begin
      r.pc = 0; r.ifid = 0; r.bub = 1;
      r.n_imm = 0; r.n_resume = 0; r.n_flag = 0;
      return r;
    end
    haz  = ex_mem_read && ((id_use1 && id_src1 == ex_rdst) || (id_use2 && id_src2 == ex_rdst));
    busy = mem_req && !mem_ready;
    imm  = m_imm_next;
    if (m_waited > 0) begin
      if (!mem_ready && m_waited < TO) begin
        r.hold = 1; r.pc = 0; r.ifid = 0; r.n_waited = m_waited + 1;
        return r;
      end
      if (!mem_ready) r.n_flag = 1;
      busy = 0;
      imm  = m_resume_imm;
    end
    if (busy) begin
      r.hold = 1; r.pc = 0; r.ifid = 0; r.n_waited = 1; r.n_resume = imm;
    end else if (imm) begin
      r.cap = 1; r.bub = 1; r.n_imm = 0;
    end else if (haz) begin
      r.pc = 0; r.ifid = 0; r.bub = 1; r.stall_ev = 1; r.n_imm = 0;
    end else begin
      r.n_imm = cu_flush;
    end
    return r;
  endfunction

  // Advance the model on each rising edge
  always @(posedge clk) begin : model_upd
    mres_t r;
    r = model_eval();
    if (rst) begin
      m_stalls <= 0;
      m_holds  <= 0;
    end else begin
      if (r.stall_ev && m_stalls < CMAX) m_stalls <= m_stalls + 1;
      if (r.hold && m_holds < CMAX) m_holds <= m_holds + 1;
    end
    m_imm_next   <= r.n_imm;
    m_waited     <= r.n_waited;
    m_resume_imm <= r.n_resume;
    m_flag       <= r.n_flag;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin : compare
    mres_t r;
    if (chk_en) begin
      r = model_eval();
      chk("cmp pc_write", {31'd0, pc_write}, {31'd0, r.pc});
      chk("cmp if_id_write", {31'd0, if_id_write}, {31'd0, r.ifid});
      chk("cmp id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, r.bub});
      chk("cmp imm_capture", {31'd0, imm_capture}, {31'd0, r.cap});
      chk("cmp pipe_hold", {31'd0, pipe_hold}, {31'd0, r.hold});
      chk("cmp mem_timeout", {31'd0, mem_timeout}, {31'd0, m_flag});
      chk("cmp stall_cnt", {30'd0, stall_cnt}, m_stalls);
      chk("cmp hold_cnt", {30'd0, hold_cnt}, m_holds);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cu_flush = 0; id_src1 = 0; id_src2 = 0; id_use1 = 0; id_use2 = 0;
    ex_mem_read = 0; ex_rdst = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1; ex_rdst = 3'd3; id_src1 = 3'd3; id_use1 = 1;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    chk_en = 1;

    // Reset forces the front end closed and injects a bubble
    @(negedge clk);
    chk("rst pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("rst stall_cnt", {30'd0, stall_cnt}, 32'd0);
    tick();

    // Load-use: exactly one stall cycle
    rst = 0; set_hazard();
    @(negedge clk);
    chk("lu pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu bubble", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    ex_mem_read = 0;
    @(negedge clk);
    chk("lu after pc_write", {31'd0, pc_write}, 32'd1);
    chk("lu after bubble", {31'd0, id_ex_bubble}, 32'd0);
    chk("lu stall_cnt", {30'd0, stall_cnt}, 32'd1);
    tick();

    // LDM: capture next cycle; a flush during IMM is ignored
    idle(); cu_flush = 1;
    @(negedge clk);
    chk("ldm issue pc_write", {31'd0, pc_write}, 32'd1);
    chk("ldm issue cap", {31'd0, imm_capture}, 32'd0);
    tick();
    @(negedge clk);
    chk("ldm cap", {31'd0, imm_capture}, 32'd1);
    chk("ldm bubble", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    cu_flush = 0;
    @(negedge clk);
    chk("ldm back cap", {31'd0, imm_capture}, 32'd0);
    chk("ldm back bubble", {31'd0, id_ex_bubble}, 32'd0);
    tick();

    // Memory wait of 3 cycles
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait hold", {31'd0, pipe_hold}, 32'd1);
      chk("wait pc_write", {31'd0, pc_write}, 32'd0);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("wait exit hold", {31'd0, pipe_hold}, 32'd0);
    chk("wait exit pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("wait hold_cnt", {30'd0, hold_cnt}, 32'd3);
    chk("wait no timeout", {31'd0, mem_timeout}, 32'd0);
    tick();

    // Wait raised during the IMM cycle
    do_reset();
    cu_flush = 1; tick();
    cu_flush = 0; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("immw hold", {31'd0, pipe_hold}, 32'd1);
      chk("immw cap", {31'd0, imm_capture}, 32'd0);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("immw exit cap", {31'd0, imm_capture}, 32'd1);
    chk("immw exit bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("immw exit hold", {31'd0, pipe_hold}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("immw after cap", {31'd0, imm_capture}, 32'd0);
    chk("immw hold_cnt", {30'd0, hold_cnt}, 32'd2);
    tick();

    // Timeout: ready stuck low
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to hold", {31'd0, pipe_hold}, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("to exit hold", {31'd0, pipe_hold}, 32'd0);
    chk("to exit pc_write", {31'd0, pc_write}, 32'd1);
    chk("to flag pre", {31'd0, mem_timeout}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("to flag", {31'd0, mem_timeout}, 32'd1);
    chk("to hold_cnt sat", {30'd0, hold_cnt}, 32'd3);
    tick(); tick(); tick();
    @(negedge clk);
    chk("to flag sticky", {31'd0, mem_timeout}, 32'd1);
    tick();

    // Reset in the middle of a wait
    mem_req = 1; mem_ready = 0;
    tick(); tick();
    rst = 1; tick();
    rst = 0; idle();
    @(negedge clk);
    chk("rstw hold", {31'd0, pipe_hold}, 32'd0);
    chk("rstw pc_write", {31'd0, pc_write}, 32'd1);
    chk("rstw hold_cnt", {30'd0, hold_cnt}, 32'd0);
    chk("rstw flag", {31'd0, mem_timeout}, 32'd0);
    tick();

    // Stall counter saturation
    set_hazard();
    for (int i = 0; i < 5; i++) tick();
    idle();
    @(negedge clk);
    chk("sat stall_cnt", {30'd0, stall_cnt}, 32'd3);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      cu_flush    = ($urandom_range(0, 3) == 0);
      id_src1     = 3'($urandom_range(0, 3));
      id_src2     = 3'($urandom_range(0, 3));
      id_use1     = 1'($urandom_range(0, 1));
      id_use2     = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rdst     = 3'($urandom_range(0, 3));
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      tick();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencing controller between the decode-stage Control_Unit and the pipeline registers. It generates PC/IF-ID write enables, ID/EX bubble insertion, and a global hold for three events: load-use hazards, two-word LDM immediate capture (signalled by the decoder's `flush`), and data-memory wait states with a timeout watchdog. It also keeps saturating stall and hold cycle counters for performance debug.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive wait cycles before the current memory access is aborted.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cu_flush` in 1: decoder flush; LDM is in ID and the next IF/ID word is its immediate.
- `id_src1`, `id_src2` in 3 each: source register numbers of the instruction in ID.
- `id_use1`, `id_use2` in 1 each: the corresponding source is actually read.
- `ex_mem_read` in 1: memRead bit of the ID/EX MEM_signals.
- `ex_rdst` in 3: destination register of the instruction in EX.
- `mem_req` in 1: MEM stage is performing a data-memory access this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC update enable.
- `if_id_write` out 1: IF/ID load enable.
- `id_ex_bubble` out 1: force zero EX/MEM/WB signals into ID/EX.
- `imm_capture` out 1: EX/MEM immediate field loads the IF/ID word.
- `pipe_hold` out 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `mem_timeout` out 1: sticky flag; a memory access was aborted.
- `stall_cnt` out CNT_W: load-use stall cycles, saturating.
- `hold_cnt` out CNT_W: `pipe_hold` cycles, saturating.

## Operation
- Definitions:
  - hazard = `ex_mem_read` & ((`id_use1` & `id_src1`==`ex_rdst`) | (`id_use2` & `id_src2`==`ex_rdst`)).
  - busy = `mem_req` & !`mem_ready`.
- States: RUN, IMM, WAIT. A 1-bit `ret` register records the state to resume after WAIT (RUN or IMM).
- Default outputs: `pc_write`=1, `if_id_write`=1, all others 0.
- RUN (checks in priority order):
  - busy: `pipe_hold`=1, `pc_write`=0, `if_id_write`=0; go to WAIT, `ret`=RUN, `wait_cnt`=1.
  - else hazard: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1; stay in RUN.
  - else `cu_flush`: LDM issues normally; go to IMM.
  - A hazard coinciding with `cu_flush` is resolved as a stall, with no transition.
- IMM (LDM is now in EX; its immediate is in IF/ID):
  - busy: hold as in RUN; go to WAIT, `ret`=IMM, `imm_capture`=0.
  - else: `imm_capture`=1, `id_ex_bubble`=1 so the immediate word is never decoded; go to RUN.
  - Hazard and `cu_flush` are ignored in IMM.
- WAIT:
  - While !`mem_ready` and `wait_cnt` < `MEM_TIMEOUT`: hold outputs; `wait_cnt` increments.
  - Exit cycle (`mem_ready`=1, or `wait_cnt`==`MEM_TIMEOUT` with `mem_ready` still 0): the memory condition is treated as ready. Outputs and next state are those of state `ret` evaluated with busy=0.
  - If the exit was a timeout, `mem_timeout` sets on that edge.
- Whenever `pipe_hold`=1, `pc_write`, `if_id_write`, `id_ex_bubble` and `imm_capture` are all 0.
- Counters:
  - `stall_cnt` increments on each hazard-stall cycle.
  - `hold_cnt` increments on each `pipe_hold` cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- Outputs are combinational from state and inputs, with no added latency. State, `ret`, `wait_cnt`, flag and counters are registered.
- Reset (synchronous, highest priority, including mid-IMM or mid-WAIT):
  - state=RUN, `ret`=RUN, `wait_cnt`=0, `mem_timeout`=0, counters=0.
  - While `rst`=1, outputs are forced: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1, `imm_capture`=0, `pipe_hold`=0.
- Load-use costs exactly 1 bubble: the bubble clears `ex_mem_read` for the next cycle.
- LDM costs exactly 1 bubble, in the cycle after the LDM leaves ID.
- A memory wait of k cycles costs k hold cycles. A timeout costs `MEM_TIMEOUT` hold cycles.
- `mem_timeout` is sticky and cleared only by `rst`.

## Structure
- Shared package holds:
  - state encoding (RUN=2'b00, IMM=2'b01, WAIT=2'b10);
  - register-number width (3);
  - the WB/MEM signal bit positions already used by Control_Unit.
- One sub-module, `sat_counter` (parameter CNT_W; ports `clk`, `rst`, `inc`, `count`), instantiated twice.

## Test plan
- Load-use: EX LDD with `ex_mem_read`=1, `ex_rdst`=3; ID ADD with `id_src1`=3, `id_use1`=1 -> one cycle with `pc_write`=0, `id_ex_bubble`=1, then normal; `stall_cnt`=1.
- LDM: `cu_flush`=1 for one cycle -> next cycle `imm_capture`=1, `id_ex_bubble`=1, state back to RUN; a second `cu_flush` in that IMM cycle is ignored.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles, then high -> `pipe_hold`=1 for exactly 3 cycles, `hold_cnt`=3, `mem_timeout`=0.
- Wait during IMM: busy raised in the IMM cycle -> hold until ready; `imm_capture` pulses once in the exit cycle.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` stuck at 0 -> 4 hold cycles, then resume, `mem_timeout`=1; it stays set until `rst`.
- Reset mid-WAIT, then counter saturation (CNT_W=2, 5 stalls):
  - reset -> next cycle state RUN, counters 0, flag 0;
  - saturation -> `stall_cnt`=3.
